// File: rtl/freertos_nios_cpu_debug_ram_ctrl.sv
// ---------------------------------------------------------------------------
// freertos_nios_cpu_debug_ram_ctrl
//
// Debug-RAM controller behind the CPU debug-slave JTAG bridge. JTAG commands
// (address load, word read, word write) arrive as one-cycle strobes with the
// bridge's jdo word. They are executed against a private 32-bit debug RAM,
// and the address auto-increments after every access. The same RAM is shared
// with the CPU through an Avalon-MM slave port. A queued JTAG access always
// wins arbitration over a new CPU request.
//
// Ports
//   clk                     : single clock for the block
//   reset_n                 : asynchronous active-low reset
//   jdo[37:0]               : bridge data word
//                             (address = jdo[26 +: ADDR_W], data = jdo[34:3])
//   take_action_ocimem_a    : strobe, load address and clear error flag
//   take_no_action_ocimem_a : strobe, queue a read at the current address
//   take_action_ocimem_b    : strobe, queue a write at the current address
//   MonDReg[31:0]           : data of the last completed JTAG read
//   monitor_ready           : no JTAG access queued or in flight
//   monitor_error           : sticky, a JTAG command was dropped
//   cpu_address             : CPU word address
//   cpu_read / cpu_write    : CPU requests
//   cpu_writedata[31:0]     : CPU write data
//   cpu_readdata[31:0]      : CPU read data, valid in the C_RD cycle
//   cpu_waitrequest         : Avalon waitrequest
// ---------------------------------------------------------------------------
module freertos_nios_cpu_debug_ram_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_J_RD = 2'd1;
    localparam logic [1:0] ST_C_RD = 2'd2;

    logic [1:0]        r_state;
    logic              r_pend;
    logic              r_pendWr;
    logic [31:0]       r_pendData;
    logic [ADDR_W-1:0] r_monA;
    logic [31:0]       r_monDReg;
    logic              r_monitorError;

    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_ramQ;

    logic [1:0]        w_nextState;
    logic [ADDR_W-1:0] w_ramAddr;
    logic [31:0]       w_ramWdata;
    logic              w_ramWe;
    logic              w_ramRe;
    logic              w_jtagWrDone;
    logic              w_cpuWrAccept;
    logic              w_unused;

    // Only the address and data fields of jdo matter here; the remaining
    // bridge bits are folded into a sink so they are visibly consumed.
    assign w_unused = ^jdo;

    // Arbitration and RAM port steering. A queued JTAG command is served
    // before any CPU request; the CPU only gets the RAM from IDLE with
    // nothing pending. J_RD and C_RD are single-cycle data-return states.
    always_comb begin
        w_nextState   = r_state;
        w_ramAddr     = r_monA;
        w_ramWdata    = r_pendData;
        w_ramWe       = 1'b0;
        w_ramRe       = 1'b0;
        w_jtagWrDone  = 1'b0;
        w_cpuWrAccept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    if (r_pendWr) begin
                        w_ramWe      = 1'b1;
                        w_jtagWrDone = 1'b1;
                    end else begin
                        w_ramRe     = 1'b1;
                        w_nextState = ST_J_RD;
                    end
                end else if (cpu_write) begin
                    w_ramAddr     = cpu_address;
                    w_ramWdata    = cpu_writedata;
                    w_ramWe       = 1'b1;
                    w_cpuWrAccept = 1'b1;
                end else if (cpu_read) begin
                    w_ramAddr   = cpu_address;
                    w_ramRe     = 1'b1;
                    w_nextState = ST_C_RD;
                end
            end
            ST_J_RD: w_nextState = ST_IDLE;
            ST_C_RD: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Single-port RAM with registered read data. The write is qualified with
    // reset_n so that nothing lands in the RAM while reset is asserted, even
    // if a CPU write is presented during reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_ramWe) begin
            r_mem[w_ramAddr] <= w_ramWdata;
        end
        if (w_ramRe) begin
            r_ramQ <= r_mem[w_ramAddr];
        end
    end

    // Control state, JTAG command capture and address pointer.
    // The FSM only touches monA/pend while a command is pending, and the
    // capture logic only touches them while nothing is pending, so the two
    // never fight over the same register in one cycle. Any strobe that
    // arrives while a command is pending is dropped and flags an error; a
    // dropped address load therefore also leaves the error flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_pend         <= 1'b0;
            r_pendWr       <= 1'b0;
            r_pendData     <= '0;
            r_monA         <= '0;
            r_monDReg      <= '0;
            r_monitorError <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_jtagWrDone || (r_state == ST_J_RD)) begin
                r_monA <= r_monA + 1'b1;
                r_pend <= 1'b0;
            end
            if (r_state == ST_J_RD) begin
                r_monDReg <= r_ramQ;
            end

            if (take_action_ocimem_a) begin
                if (r_pend) begin
                    r_monitorError <= 1'b1;
                end else begin
                    r_monA         <= jdo[26 +: ADDR_W];
                    r_monitorError <= 1'b0;
                end
            end else if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                if (r_pend) begin
                    r_monitorError <= 1'b1;
                end else begin
                    r_pend     <= 1'b1;
                    r_pendWr   <= take_action_ocimem_b;
                    r_pendData <= jdo[34:3];
                end
            end
        end
    end

    // Read data is forced to zero outside C_RD so the bus never shows stale
    // or uninitialised RAM output while no transfer is completing.
    assign cpu_readdata    = (r_state == ST_C_RD) ? r_ramQ : 32'h0;
    assign cpu_waitrequest = !(w_cpuWrAccept || (r_state == ST_C_RD));
    assign monitor_ready   = !r_pend && (r_state != ST_J_RD);
    assign MonDReg         = r_monDReg;
    assign monitor_error   = r_monitorError;

endmodule

// File: tb/tb_freertos_nios_cpu_debug_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freertos_nios_cpu_debug_ram_ctrl
//
// Directed plus randomized bench for the debug-RAM controller. A behavioural
// model (a plain word array, an address counter and the last read word)
// tracks what the RAM and monitor registers must hold after each JTAG or CPU
// transaction. Cycle-exact latencies are checked at the directed steps.
// ---------------------------------------------------------------------------
module tb_freertos_nios_cpu_debug_ram_ctrl;

    localparam int K_LOAD = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] modelMem [256];
    int          modelMonA;
    logic [31:0] modelMonD;

    freertos_nios_cpu_debug_ram_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case some handshake never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulse one JTAG strobe for exactly one clock edge.
    task automatic applyStimulus(input int kind, input logic [31:0] value);
        jdo = '0;
        case (kind)
            K_LOAD: begin
                jdo[33:26] = value[7:0];
                take_action_ocimem_a = 1'b1;
            end
            K_WR: begin
                jdo[34:3] = value;
                take_action_ocimem_b = 1'b1;
            end
            default: take_no_action_ocimem_a = 1'b1;
        endcase
        cycle();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic waitJtagIdle(input string tag);
        for (int i = 0; i < 20 && !monitor_ready; i++) cycle();
        checkOutput(tag, {31'b0, monitor_ready}, 32'd1);
    endtask

    task automatic jtagLoad(input logic [7:0] a);
        applyStimulus(K_LOAD, {24'b0, a});
        modelMonA = a;
    endtask

    task automatic jtagWrite(input logic [31:0] d);
        applyStimulus(K_WR, d);
        waitJtagIdle("jtag_wr_done");
        modelMem[modelMonA] = d;
        modelMonA = (modelMonA + 1) % 256;
    endtask

    task automatic jtagRead();
        applyStimulus(K_RD, 32'h0);
        waitJtagIdle("jtag_rd_done");
        modelMonD = modelMem[modelMonA];
        modelMonA = (modelMonA + 1) % 256;
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, output int waits);
        cpu_address   = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        #1;
        waits = 0;
        for (int i = 0; i < 20 && cpu_waitrequest; i++) begin
            cycle();
            waits++;
        end
        checkOutput("cpu_wr_accept", {31'b0, cpu_waitrequest}, 32'd0);
        cycle();
        cpu_write = 1'b0;
        modelMem[a] = d;
    endtask

    task automatic cpuRead(input logic [7:0] a, output logic [31:0] data, output int waits);
        cpu_address = a;
        cpu_read    = 1'b1;
        #1;
        waits = 0;
        for (int i = 0; i < 20 && cpu_waitrequest; i++) begin
            cycle();
            waits++;
        end
        checkOutput("cpu_rd_accept", {31'b0, cpu_waitrequest}, 32'd0);
        data = cpu_readdata;
        cycle();
        cpu_read = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dj;
        logic [31:0] d5;
        logic [31:0] d6;
        logic [31:0] va;
        int          w;
        int          op;
        logic [7:0]  a;

        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        cpu_address             = '0;
        cpu_read                = 1'b0;
        cpu_write               = 1'b0;
        cpu_writedata           = '0;
        modelMonA               = 0;
        modelMonD               = 32'h0;
        for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;

        // Reset values.
        cycle();
        cycle();
        checkOutput("rst_mondreg", MonDReg, 32'h0);
        checkOutput("rst_ready", {31'b0, monitor_ready}, 32'd1);
        checkOutput("rst_error", {31'b0, monitor_error}, 32'd0);
        checkOutput("rst_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
        checkOutput("rst_monA", {24'b0, dut.r_monA}, 32'h0);
        reset_n = 1'b1;
        cycle();

        // Address load, two writes, CPU read-back.
        jtagLoad(8'h10);
        checkOutput("load_monA", {24'b0, dut.r_monA}, 32'h10);
        applyStimulus(K_WR, 32'hDEADBEEF);
        checkOutput("wr_ready_n1", {31'b0, monitor_ready}, 32'd0);
        cycle();
        checkOutput("wr_ready_n2", {31'b0, monitor_ready}, 32'd1);
        checkOutput("wr_monA_n2", {24'b0, dut.r_monA}, 32'h11);
        modelMem[8'h10] = 32'hDEADBEEF;
        modelMonA = 8'h11;
        jtagWrite(32'h12345678);
        checkOutput("wr2_monA", {24'b0, dut.r_monA}, modelMonA);
        cpuRead(8'h11, d, w);
        checkOutput("cpu_rd_11", d, 32'h12345678);
        checkOutput("cpu_rd_waits", w, 32'd1);
        cpuRead(8'h10, d, w);
        checkOutput("cpu_rd_10", d, modelMem[8'h10]);

        // CPU write, then JTAG read with cycle-exact latency.
        cpuWrite(8'h20, 32'hA5A5A5A5, w);
        checkOutput("cpu_wr_waits", w, 32'd0);
        jtagLoad(8'h20);
        applyStimulus(K_RD, 32'h0);
        checkOutput("rd_ready_n1", {31'b0, monitor_ready}, 32'd0);
        cycle();
        checkOutput("rd_ready_n2", {31'b0, monitor_ready}, 32'd0);
        cycle();
        checkOutput("rd_ready_n3", {31'b0, monitor_ready}, 32'd1);
        checkOutput("rd_mondreg_n3", MonDReg, 32'hA5A5A5A5);
        checkOutput("rd_monA", {24'b0, dut.r_monA}, 32'h21);
        modelMonD = 32'hA5A5A5A5;
        modelMonA = 8'h21;

        // Address wrap-around.
        r1 = $urandom;
        r2 = $urandom;
        jtagLoad(8'hFF);
        jtagWrite(r1);
        jtagWrite(r2);
        checkOutput("wrap_monA", {24'b0, dut.r_monA}, 32'h01);
        cpuRead(8'hFF, d, w);
        checkOutput("wrap_ram_ff", d, r1);
        cpuRead(8'h00, d, w);
        checkOutput("wrap_ram_00", d, r2);

        // Overrun: back-to-back read strobes, then a load while pending.
        cpuWrite(8'h30, $urandom, w);
        cpuWrite(8'h31, $urandom, w);
        jtagLoad(8'h30);
        checkOutput("ovr_err_clear", {31'b0, monitor_error}, 32'd0);
        applyStimulus(K_RD, 32'h0);
        applyStimulus(K_RD, 32'h0);
        checkOutput("ovr_err_set", {31'b0, monitor_error}, 32'd1);
        waitJtagIdle("ovr_done");
        checkOutput("ovr_mondreg", MonDReg, modelMem[8'h30]);
        checkOutput("ovr_single_rd", {24'b0, dut.r_monA}, 32'h31);
        checkOutput("ovr_err_sticky", {31'b0, monitor_error}, 32'd1);
        applyStimulus(K_RD, 32'h0);
        applyStimulus(K_LOAD, 32'h90);
        waitJtagIdle("ovr_load_done");
        checkOutput("ovr_load_ignored", {24'b0, dut.r_monA}, 32'h32);
        checkOutput("ovr_load_mondreg", MonDReg, modelMem[8'h31]);
        checkOutput("ovr_load_err", {31'b0, monitor_error}, 32'd1);
        jtagLoad(8'h40);
        checkOutput("ovr_err_cleared", {31'b0, monitor_error}, 32'd0);
        modelMonD = modelMem[8'h31];

        // Contention: CPU read accepted in the same cycle as a JTAG write.
        d5 = $urandom;
        d6 = $urandom;
        dj = $urandom;
        cpuWrite(8'h05, d5, w);
        cpu_address = 8'h05;
        cpu_read    = 1'b1;
        jdo         = '0;
        jdo[34:3]   = dj;
        take_action_ocimem_b = 1'b1;
        #1;
        checkOutput("cont_accept_wr", {31'b0, cpu_waitrequest}, 32'd1);
        cycle();
        take_action_ocimem_b = 1'b0;
        cpu_read = 1'b0;
        checkOutput("cont_crd_waitreq", {31'b0, cpu_waitrequest}, 32'd0);
        checkOutput("cont_crd_data", cpu_readdata, d5);
        checkOutput("cont_crd_ready", {31'b0, monitor_ready}, 32'd0);
        cycle();
        cpu_address   = 8'h06;
        cpu_writedata = d6;
        cpu_write     = 1'b1;
        #1;
        checkOutput("cont_cpu_blocked", {31'b0, cpu_waitrequest}, 32'd1);
        checkOutput("cont_jwr_late", {24'b0, dut.r_monA}, 32'h40);
        cycle();
        checkOutput("cont_jwr_done", {24'b0, dut.r_monA}, 32'h41);
        checkOutput("cont_ready", {31'b0, monitor_ready}, 32'd1);
        checkOutput("cont_cpu_go", {31'b0, cpu_waitrequest}, 32'd0);
        cycle();
        cpu_write = 1'b0;
        modelMem[8'h40] = dj;
        modelMem[8'h06] = d6;
        modelMonA = 8'h41;
        cpuRead(8'h40, d, w);
        checkOutput("cont_ram_40", d, dj);
        cpuRead(8'h06, d, w);
        checkOutput("cont_ram_06", d, d6);

        // Randomized mix against the model, starting from fully known RAM.
        for (int i = 0; i < 256; i++) cpuWrite(i[7:0], $urandom, w);
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    a = 8'($urandom_range(0, 255));
                    jtagLoad(a);
                    checkOutput("rnd_load_monA", {24'b0, dut.r_monA}, modelMonA);
                    checkOutput("rnd_load_err", {31'b0, monitor_error}, 32'd0);
                end
                1: begin
                    jtagWrite($urandom);
                    checkOutput("rnd_wr_monA", {24'b0, dut.r_monA}, modelMonA);
                end
                2: begin
                    jtagRead();
                    checkOutput("rnd_rd_mondreg", MonDReg, modelMonD);
                    checkOutput("rnd_rd_monA", {24'b0, dut.r_monA}, modelMonA);
                end
                3: begin
                    cpuWrite(8'($urandom_range(0, 255)), $urandom, w);
                    checkOutput("rnd_cpu_wr_waits", w, 32'd0);
                end
                default: begin
                    a = 8'($urandom_range(0, 255));
                    cpuRead(a, d, w);
                    checkOutput("rnd_cpu_rd_data", d, modelMem[a]);
                    checkOutput("rnd_cpu_rd_waits", w, 32'd1);
                end
            endcase
        end

        // Reset asserted while in J_RD with the error flag set.
        jtagLoad(8'h50);
        applyStimulus(K_RD, 32'h0);
        applyStimulus(K_RD, 32'h0);
        checkOutput("jrd_pre_ready", {31'b0, monitor_ready}, 32'd0);
        checkOutput("jrd_pre_err", {31'b0, monitor_error}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("jrd_rst_mondreg", MonDReg, 32'h0);
        checkOutput("jrd_rst_ready", {31'b0, monitor_ready}, 32'd1);
        checkOutput("jrd_rst_monA", {24'b0, dut.r_monA}, 32'h0);
        checkOutput("jrd_rst_err", {31'b0, monitor_error}, 32'd0);
        checkOutput("jrd_rst_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
        cycle();
        reset_n = 1'b1;
        cycle();
        cpuWrite(8'h51, $urandom, w);
        checkOutput("jrd_rst_idle", w, 32'd0);

        // Reset while a JTAG write is pending must not write the RAM.
        va = $urandom;
        cpuWrite(8'h60, va, w);
        jtagLoad(8'h60);
        applyStimulus(K_WR, ~va);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        cpuRead(8'h60, d, w);
        checkOutput("rst_no_write", d, va);
        checkOutput("rst_wr_monA", {24'b0, dut.r_monA}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
